c499_key_loader: RTL and testbench

- Serial key-loading stage directly upstream of the locked C499 error-correction core.
- Shifts a 27-bit key plus one even-parity bit in from a serial port and checks the parity.
- On a good load, commits the key to a held parallel bus that drives the core's `keyinput0..keyinput26` pins.
- Flags errors, times out stalled loads, and zeroizes the key on error or on request, so the core only sees a complete, verified key.

---
 rtl/c499_key_pkg.sv | 15 +
 rtl/c499_key_loader.sv | 130 +++++++++++++
 tb/tb_c499_key_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/c499_key_pkg.sv
// Shared types and constants for the C499 serial key loader.
package c499_key_pkg;

  localparam int C499_KEY_W       = 27;
  localparam int C499_KEY_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } key_state_t;

endpackage

// File: rtl/c499_key_loader.sv
// Serial key loader: shifts KEY_W key bits plus an even-parity bit, verifies
// them and presents a held key to the C499 core only after a clean load.
module c499_key_loader
  import c499_key_pkg::*;
#(
  parameter int KEY_W   = C499_KEY_W,
  parameter int TIMEOUT = C499_KEY_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic             key_clear,
  input  logic             key_sdi,
  input  logic             key_sdi_valid,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(KEY_W);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  key_state_t       state_q,  state_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] key_q,    key_d;
  logic [CNT_W-1:0] bcnt_q,   bcnt_d;
  logic [TMO_W-1:0] tcnt_q,   tcnt_d;
  logic             par_q,    par_d;
  logic             kval_q,   kval_d;
  logic             kerr_q,   kerr_d;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    key_d    = key_q;
    bcnt_d   = bcnt_q;
    tcnt_d   = tcnt_q;
    par_d    = par_q;
    kval_d   = kval_q;
    kerr_d   = kerr_q;

    if (key_clear) begin
      state_d  = ST_IDLE;
      shadow_d = '0;
      key_d    = '0;
      bcnt_d   = '0;
      tcnt_d   = '0;
      par_d    = 1'b0;
      kval_d   = 1'b0;
      kerr_d   = 1'b0;
    end else if (key_load && state_q != ST_CHECK) begin
      // The committed key stays on the bus until the new load verifies.
      state_d  = ST_SHIFT;
      shadow_d = '0;
      bcnt_d   = '0;
      tcnt_d   = '0;
      par_d    = 1'b0;
      kval_d   = 1'b0;
      kerr_d   = 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (key_sdi_valid) begin
            tcnt_d = '0;
            if (bcnt_q == BIT_LAST) begin
              par_d   = key_sdi;
              state_d = ST_CHECK;
            end else begin
              shadow_d = {shadow_q[KEY_W-2:0], key_sdi};
              bcnt_d   = bcnt_q + CNT_W'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TMO_W'(1);
            if (tcnt_d == TMO_MAX) begin
              state_d = ST_ERR;
              key_d   = '0;
              kval_d  = 1'b0;
              kerr_d  = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (^shadow_q ^ par_q) begin
            state_d = ST_ERR;
            key_d   = '0;
            kval_d  = 1'b0;
            kerr_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            key_d   = shadow_q;
            kval_d  = 1'b1;
          end
        end
        ST_IDLE, ST_DONE, ST_ERR: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      key_q    <= '0;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
      par_q    <= 1'b0;
      kval_q   <= 1'b0;
      kerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
      bcnt_q   <= bcnt_d;
      tcnt_q   <= tcnt_d;
      par_q    <= par_d;
      kval_q   <= kval_d;
      kerr_q   <= kerr_d;
    end
  end

  assign keyinput  = key_q;
  assign key_valid = kval_q;
  assign key_err   = kerr_q;
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_c499_key_loader.sv
// Directed bench for c499_key_loader with hand-computed expected keys.
module tb_c499_key_loader;
  localparam int KW = 27;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_load = 1'b0;
  logic          key_clear = 1'b0;
  logic          key_sdi = 1'b0;
  logic          key_sdi_valid = 1'b0;
  logic [KW-1:0] keyinput;
  logic          key_valid, key_err, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c499_key_loader #(.KEY_W(KW), .TIMEOUT(255)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_load      (key_load),
    .key_clear     (key_clear),
    .key_sdi       (key_sdi),
    .key_sdi_valid (key_sdi_valid),
    .keyinput      (keyinput),
    .key_valid     (key_valid),
    .key_err       (key_err),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    key_sdi       = b;
    key_sdi_valid = 1'b1;
    tick();
    key_sdi_valid = 1'b0;
  endtask

  // Sends bits key[hi] down to key[lo], MSB first.
  task automatic send_range(input logic [KW-1:0] key, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(key[i]);
  endtask

  task automatic chk_out(input string tag, input logic [KW-1:0] k, input logic v,
                         input logic e, input logic b);
    chk({tag, ".key"},   32'(keyinput),  32'(k));
    chk({tag, ".valid"}, 32'(key_valid), 32'(v));
    chk({tag, ".err"},   32'(key_err),   32'(e));
    chk({tag, ".busy"},  32'(busy),      32'(b));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_out("rst", '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Stray valid bits in IDLE do nothing
    send_bit(1'b1);
    send_bit(1'b1);
    chk_out("idle_sdi", '0, 1'b0, 1'b0, 1'b0);

    // Async reset in the middle of SHIFT after 10 bits
    do_load();
    chk("load.busy", 32'(busy), 32'd1);
    send_range(27'h7FFFFFF, 26, 17);
    #2 rst_n = 1'b0;
    #1 chk_out("midrst", '0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("midrst_hold", '0, 1'b0, 1'b0, 1'b0);

    // Clean load after reset: 27'h5A5A5A5 has 14 ones, parity 0
    do_load();
    send_range(27'h5A5A5A5, 26, 0);
    send_bit(1'b0);
    tick();
    chk_out("load5a", 27'h5A5A5A5, 1'b1, 1'b0, 1'b0);

    // All ones, parity 1: cycle-exact completion
    do_load();
    chk_out("ones.e0", 27'h5A5A5A5, 1'b0, 1'b0, 1'b1);
    send_range(27'h7FFFFFF, 26, 0);
    send_bit(1'b1);
    chk_out("ones.e28", 27'h5A5A5A5, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("ones.e29", 27'h7FFFFFF, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("ones.hold", 27'h7FFFFFF, 1'b1, 1'b0, 1'b0);

    // Bad parity wipes the previously committed key
    do_load();
    send_range(27'h0000001, 26, 0);
    send_bit(1'b0);
    chk("bad.pre_key", 32'(keyinput), 32'h7FFFFFF);
    tick();
    chk_out("bad", '0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("bad.sticky", 32'(key_err), 32'd1);
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    chk_out("bad.clr", '0, 1'b0, 1'b0, 1'b0);

    // Stall of TIMEOUT cycles after bit 5 aborts
    do_load();
    send_range(27'h7FFFFFF, 26, 22);
    for (int i = 0; i < 254; i++) tick();
    chk("tmo254.busy", 32'(busy), 32'd1);
    chk("tmo254.err", 32'(key_err), 32'd0);
    tick();
    chk_out("tmo255", '0, 1'b0, 1'b1, 1'b0);

    // Stall of TIMEOUT-1 cycles then resume: 27'h0F0F0F0 has 12 ones, parity 0
    do_load();
    chk("tmo.reload_err", 32'(key_err), 32'd0);
    send_range(27'h0F0F0F0, 26, 22);
    for (int i = 0; i < 254; i++) tick();
    send_range(27'h0F0F0F0, 21, 0);
    send_bit(1'b0);
    tick();
    chk_out("stall254", 27'h0F0F0F0, 1'b1, 1'b0, 1'b0);

    // Restart at bit 12; sdi in the load cycle is ignored. 27'h2AAAAAA: 13 ones, parity 1
    do_load();
    send_range(27'h7FFFFFF, 26, 15);
    key_load      = 1'b1;
    key_sdi       = 1'b1;
    key_sdi_valid = 1'b1;
    tick();
    key_load      = 1'b0;
    key_sdi_valid = 1'b0;
    chk_out("restart", 27'h0F0F0F0, 1'b0, 1'b0, 1'b1);
    send_range(27'h2AAAAAA, 26, 0);
    send_bit(1'b1);
    tick();
    chk_out("restart.done", 27'h2AAAAAA, 1'b1, 1'b0, 1'b0);

    // key_load during CHECK is ignored
    do_load();
    send_range(27'h5A5A5A5, 26, 0);
    send_bit(1'b0);
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk_out("chk_load", 27'h5A5A5A5, 1'b1, 1'b0, 1'b0);

    // Clear and load together in DONE act as clear
    key_clear = 1'b1;
    key_load  = 1'b1;
    tick();
    key_clear = 1'b0;
    key_load  = 1'b0;
    chk_out("clr_load", '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("clr_load.busy2", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
